// File: rtl/body_fetch_master.sv
// body_fetch_master: Avalon-MM read master that copies the per-body record
// table (radius, x, y, z per body) from memory into the renderer-side body
// registers. One outstanding read at a time. A stalled read aborts the fetch
// after TIMEOUT cycles without data.
//
// Bus handshake: a read is issued by holding AVL_READ high with a stable
// AVL_ADDR. It is accepted on the first rising edge that sees
// AVL_WAITREQUEST low. Exactly one AVL_READDATAVALID is then awaited before
// the next read is issued. Read data strobes outside the WAIT state are
// ignored.
module body_fetch_master #(
    parameter int NUM_BODIES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] BASE_ADDR,
    output logic        AVL_READ,
    output logic [31:0] AVL_ADDR,
    output logic [3:0]  AVL_BYTE_EN,
    input  logic        AVL_WAITREQUEST,
    input  logic        AVL_READDATAVALID,
    input  logic [31:0] AVL_READDATA,
    output logic        BODY_WE,
    output logic [3:0]  BODY_IDX,
    output logic [1:0]  BODY_FIELD,
    output logic [31:0] BODY_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        TIMEOUT_ERR,
    output logic [1:0]  DBG_STATE
);

    localparam logic [5:0] LAST_WORD = 6'(4 * NUM_BODIES - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [5:0]  word_q, word_d;
    logic [5:0]  wr_word_q, wr_word_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        read_q, read_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        terr_q, terr_d;

    logic [5:0]  word_nxt;
    logic        unused_base_lsbs;

    // Byte-address offsets are whole words, so the two low address bits are dropped.
    assign unused_base_lsbs = ^BASE_ADDR[1:0];
    assign word_nxt         = word_q + 6'd1;

    // State and registered outputs; reset aborts any fetch with no DONE pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            base_q    <= 32'd0;
            word_q    <= 6'd0;
            wr_word_q <= 6'd0;
            tmo_q     <= 8'd0;
            read_q    <= 1'b0;
            addr_q    <= 32'd0;
            we_q      <= 1'b0;
            data_q    <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            word_q    <= word_d;
            wr_word_q <= wr_word_d;
            tmo_q     <= tmo_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
        end
    end

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        word_d    = word_q;
        wr_word_d = wr_word_q;
        tmo_d     = tmo_q;
        read_d    = read_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        data_d    = data_q;
        done_d    = 1'b0;
        terr_d    = terr_q;

        case (state_q)
            S_IDLE: begin
                // BUSY is still high in the DONE cycle, so a START there is ignored.
                if (START && !busy_q) begin
                    base_d  = {BASE_ADDR[31:2], 2'b00};
                    addr_d  = {BASE_ADDR[31:2], 2'b00};
                    word_d  = 6'd0;
                    terr_d  = 1'b0;
                    read_d  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!AVL_WAITREQUEST) begin
                    read_d  = 1'b0;
                    tmo_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (AVL_READDATAVALID) begin
                    we_d      = 1'b1;
                    data_d    = AVL_READDATA;
                    wr_word_d = word_q;
                    tmo_d     = 8'd0;
                    if (word_q == LAST_WORD) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        word_d  = word_nxt;
                        addr_d  = base_q + {24'd0, word_nxt, 2'b00};
                        read_d  = 1'b1;
                        state_d = S_REQ;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                read_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) || done_d;
    end

    assign AVL_READ    = read_q;
    assign AVL_ADDR    = addr_q;
    assign AVL_BYTE_EN = 4'b1111;
    assign BODY_WE     = we_q;
    assign BODY_IDX    = wr_word_q[5:2];
    assign BODY_FIELD  = wr_word_q[1:0];
    assign BODY_DATA   = data_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = terr_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_body_fetch_master.sv
// Testbench for body_fetch_master: a latency-1 memory model returning
// data = address, with injectable waitrequest stalls, dropped read data and
// spurious data strobes; written words are checked against an expected queue.
module tb_body_fetch_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic        avl_read;
  logic [31:0] avl_addr;
  logic [3:0]  avl_byte_en;
  logic        avl_waitrequest = 1'b0;
  logic        avl_readdatavalid = 1'b0;
  logic [31:0] avl_readdata = 32'd0;
  logic        body_we;
  logic [3:0]  body_idx;
  logic [1:0]  body_field;
  logic [31:0] body_data;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  body_fetch_master #(.NUM_BODIES(2), .TIMEOUT(5)) dut (
    .CLK(clk), .RESET(rst), .START(start), .BASE_ADDR(base_addr),
    .AVL_READ(avl_read), .AVL_ADDR(avl_addr), .AVL_BYTE_EN(avl_byte_en),
    .AVL_WAITREQUEST(avl_waitrequest), .AVL_READDATAVALID(avl_readdatavalid),
    .AVL_READDATA(avl_readdata), .BODY_WE(body_we), .BODY_IDX(body_idx),
    .BODY_FIELD(body_field), .BODY_DATA(body_data), .BUSY(busy), .DONE(done),
    .TIMEOUT_ERR(timeout_err), .DBG_STATE(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [37:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int t0 = 0;
  int first_we = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int we_cnt = 0;
  int acc_cnt = 0;
  int hold_cnt = 0;
  logic busy_at_done = 1'b0;

  // memory model controls
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          stall_left = 0;
  logic [31:0] stall_addr = 32'd0;
  logic        sup_en = 1'b0;
  logic [31:0] sup_addr = 32'd0;
  logic        spur = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model (drives slave inputs at negedge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      avl_readdatavalid = 1'b0;
      avl_waitrequest = 1'b0;
    end else begin
      avl_readdatavalid = 1'b0;
      if (spur) begin
        avl_readdatavalid = 1'b1;
        avl_readdata = 32'hDEADBEEF;
        spur = 1'b0;
      end
      if (pend) begin
        pend = 1'b0;
        if (!(sup_en && pend_addr == sup_addr)) begin
          avl_readdatavalid = 1'b1;
          avl_readdata = pend_addr;
        end
      end
      if (avl_read) begin
        if (stall_left > 0 && avl_addr == stall_addr) begin
          avl_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avl_waitrequest = 1'b0;
          pend = 1'b1;
          pend_addr = avl_addr;
          acc_cnt++;
        end
      end else begin
        avl_waitrequest = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (avl_read && avl_addr == 32'h0000_1008) hold_cnt++;
      if (body_we) begin
        we_cnt++;
        if (first_we < 0) first_we = cyc - t0;
        if (exp_q.size() == 0) check("spurious_we", 64'(body_data), 64'h1_0000_0000);
        else check("we_word", {26'd0, body_idx, body_field, body_data}, {26'd0, exp_q.pop_front()});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
        busy_at_done = busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_words(input logic [31:0] base, input int n);
    for (int w = 0; w < n; w++) begin
      logic [5:0] wv;
      wv = 6'(w);
      exp_q.push_back({wv[5:2], wv[1:0], base + 32'(4 * w)});
    end
  endtask

  // Leaves the caller at the negedge of cycle 1 (START sampled at edge 0).
  task automatic start_fetch(input logic [31:0] base, input logic [31:0] exp_addr);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    t0 = cyc;
    first_we = -1;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b0;
    check("c1_read", 64'(avl_read), 64'd1);
    check("c1_addr", 64'(avl_addr), 64'(exp_addr));
    check("c1_busy", 64'(busy), 64'd1);
    check("c1_terr_clear", 64'(timeout_err), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 64'(done_cnt != d0), 64'd1);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int we0;
    int acc0;
    int dn0;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_read", 64'(avl_read), 64'd0);
    check("rst_addr", 64'(avl_addr), 64'd0);
    check("rst_byte_en", 64'(avl_byte_en), 64'hF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(body_we), 64'd0);
    check("rst_terr", 64'(timeout_err), 64'd0);

    // basic fetch
    we0 = we_cnt; acc0 = acc_cnt;
    push_words(32'h0000_1000, 8);
    start_fetch(32'h0000_1000, 32'h0000_1000);
    wait_done(100);
    check("basic_first_we", 64'(first_we), 64'd3);
    check("basic_done_cyc", 64'(done_cyc), 64'd17);
    check("basic_busy_at_done", 64'(busy_at_done), 64'd1);
    check("basic_busy_after", 64'(busy), 64'd0);
    check("basic_we_cnt", 64'(we_cnt - we0), 64'd8);
    check("basic_acc_cnt", 64'(acc_cnt - acc0), 64'd8);
    check("basic_terr", 64'(timeout_err), 64'd0);
    check("basic_exp_empty", 64'(exp_q.size()), 64'd0);

    // waitrequest held 3 cycles on word 2
    we0 = we_cnt; acc0 = acc_cnt; hold_cnt = 0;
    stall_addr = 32'h0000_1008; stall_left = 3;
    push_words(32'h0000_1000, 8);
    start_fetch(32'h0000_1000, 32'h0000_1000);
    wait_done(100);
    check("wr_done_cyc", 64'(done_cyc), 64'd20);
    check("wr_addr_hold_cycles", 64'(hold_cnt), 64'd4);
    check("wr_acc_cnt", 64'(acc_cnt - acc0), 64'd8);
    check("wr_we_cnt", 64'(we_cnt - we0), 64'd8);
    check("wr_exp_empty", 64'(exp_q.size()), 64'd0);

    // timeout on word 5
    we0 = we_cnt;
    sup_en = 1'b1; sup_addr = 32'h0000_1014;
    push_words(32'h0000_1000, 5);
    start_fetch(32'h0000_1000, 32'h0000_1000);
    wait_done(100);
    sup_en = 1'b0;
    check("tmo_done_cyc", 64'(done_cyc), 64'd17);
    check("tmo_terr", 64'(timeout_err), 64'd1);
    check("tmo_we_cnt", 64'(we_cnt - we0), 64'd5);
    check("tmo_busy_after", 64'(busy), 64'd0);
    check("tmo_exp_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("tmo_terr_sticky", 64'(timeout_err), 64'd1);

    // refetch after timeout clears the flag
    we0 = we_cnt;
    push_words(32'h0000_1000, 8);
    start_fetch(32'h0000_1000, 32'h0000_1000);
    wait_done(100);
    check("refetch_done_cyc", 64'(done_cyc), 64'd17);
    check("refetch_we_cnt", 64'(we_cnt - we0), 64'd8);
    check("refetch_terr", 64'(timeout_err), 64'd0);

    // address wrap, with START pulses while busy (including the DONE cycle)
    we0 = we_cnt; acc0 = acc_cnt; dn0 = done_cnt;
    exp_q.push_back({4'd0, 2'd0, 32'hFFFF_FFF0});
    exp_q.push_back({4'd0, 2'd1, 32'hFFFF_FFF4});
    exp_q.push_back({4'd0, 2'd2, 32'hFFFF_FFF8});
    exp_q.push_back({4'd0, 2'd3, 32'hFFFF_FFFC});
    exp_q.push_back({4'd1, 2'd0, 32'h0000_0000});
    exp_q.push_back({4'd1, 2'd1, 32'h0000_0004});
    exp_q.push_back({4'd1, 2'd2, 32'h0000_0008});
    exp_q.push_back({4'd1, 2'd3, 32'h0000_000C});
    start_fetch(32'hFFFF_FFF3, 32'hFFFF_FFF0);
    repeat (4) @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_5000;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wrap_done_cnt", 64'(done_cnt - dn0), 64'd1);
    check("wrap_done_cyc", 64'(done_cyc), 64'd17);
    repeat (4) @(negedge clk);
    check("wrap_busy_ignored", 64'(busy), 64'd0);
    check("wrap_acc_cnt", 64'(acc_cnt - acc0), 64'd8);
    check("wrap_we_cnt", 64'(we_cnt - we0), 64'd8);
    check("wrap_exp_empty", 64'(exp_q.size()), 64'd0);

    // spurious read data in IDLE
    we0 = we_cnt;
    spur = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_we_cnt", 64'(we_cnt - we0), 64'd0);
    check("spur_busy", 64'(busy), 64'd0);

    // asynchronous reset while waiting on word 3
    we0 = we_cnt; dn0 = done_cnt;
    sup_en = 1'b1; sup_addr = 32'h0000_200C;
    push_words(32'h0000_2000, 3);
    start_fetch(32'h0000_2000, 32'h0000_2000);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_read", 64'(avl_read), 64'd0);
    check("arst_addr", 64'(avl_addr), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_we", 64'(body_we), 64'd0);
    check("arst_data", 64'(body_data), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_idx", 64'({body_idx, body_field}), 64'd0);
    check("arst_we_cnt", 64'(we_cnt - we0), 64'd3);
    check("arst_exp_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sup_en = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_no_done", 64'(done_cnt - dn0), 64'd0);

    // clean fetch after reset
    we0 = we_cnt;
    push_words(32'h0000_1000, 8);
    start_fetch(32'h0000_1000, 32'h0000_1000);
    wait_done(100);
    check("post_rst_done_cyc", 64'(done_cyc), 64'd17);
    check("post_rst_we_cnt", 64'(we_cnt - we0), 64'd8);
    check("post_rst_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/body_fetch_master.md
# body_fetch_master

Avalon-MM read master that fetches the per-body record table (scaled radius, x, y, z) from system memory once per trigger. It emits each word on a body-table write port for the renderer-side register copy. It is the initiator counterpart of the body register slave: same 4-word-per-body field order, driven from the master side. Typically triggered once per frame from the VGA vertical-sync edge.

## Interface
Parameters:
- NUM_BODIES, 2: bodies per fetch, 1..16.
- TIMEOUT, 255: max cycles to wait for read data after a read is accepted, 1..255.

Ports:
- CLK  in  1  system clock (50 MHz).
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle trigger; ignored while BUSY.
- BASE_ADDR  in  32  byte address of body 0 record; sampled on accepted START; bits [1:0] forced to 0.
- AVL_READ  out  1  Avalon-MM read request.
- AVL_ADDR  out  32  Avalon-MM byte address.
- AVL_BYTE_EN  out  4  always 4'b1111.
- AVL_WAITREQUEST  in  1  slave stall.
- AVL_READDATAVALID  in  1  read data strobe.
- AVL_READDATA  in  32  read data.
- BODY_WE  out  1  one-cycle write strobe for one fetched word.
- BODY_IDX  out  4  body index 0..NUM_BODIES-1.
- BODY_FIELD  out  2  0 radius, 1 x, 2 y, 3 z.
- BODY_DATA  out  32  fetched word.
- BUSY  out  1  fetch in progress.
- DONE  out  1  one-cycle pulse at end of fetch, normal or aborted.
- TIMEOUT_ERR  out  1  sticky abort flag; cleared on next accepted START.

## Operation
- All outputs registered. Reset value of every output is 0, except AVL_BYTE_EN = 4'b1111. State returns to IDLE, counters are cleared.
- States and transitions:
  - IDLE: on START, latch base, clear word counter and TIMEOUT_ERR, go to REQ.
  - REQ: AVL_READ=1 and AVL_ADDR held stable. A read is accepted on an edge with AVL_WAITREQUEST=0; then go to WAIT.
  - WAIT: AVL_READ=0; timeout counter increments each cycle.
    - On AVL_READDATAVALID: register the word to BODY_*, pulse BODY_WE, advance the word counter, reset the timeout counter. Go to REQ, or to IDLE with DONE if this was the last word.
    - If the counter reaches TIMEOUT without valid data: set TIMEOUT_ERR, pulse DONE, go to IDLE. No BODY_WE is issued for the missing word.
- One outstanding read at most. AVL_READDATAVALID is ignored in IDLE and REQ.
- Word counter w spans 0..4*NUM_BODIES-1.
  - BODY_IDX = w[5:2] and BODY_FIELD = w[1:0].
  - AVL_ADDR = base + 4*w, modulo 2^32 (wrap-around allowed, no error).
- START while BUSY: ignored, with no effect on the address or counters.
- RESET asserted mid-fetch: immediate abort, all outputs 0, no DONE pulse. The slave-side read is abandoned.

## Timing
- START sampled at edge 0. AVL_READ is high from cycle 1 with AVL_ADDR = base.
- Per word, minimum 2 cycles (zero waitrequest, read latency 1):
  - request accepted at cycle k;
  - READDATAVALID at cycle k+1;
  - BODY_WE high in cycle k+2, together with AVL_READ for the next word.
- Every waitrequest cycle or extra latency cycle adds one cycle.
- Last word: BODY_WE and DONE are high in the same cycle. BUSY falls the following cycle.
- BUSY is high from cycle 1 through the DONE cycle inclusive.
- NUM_BODIES=2 with zero stalls: first BODY_WE at cycle 3, last BODY_WE and DONE at cycle 17.
- Timeout: DONE and TIMEOUT_ERR rise in the cycle after the TIMEOUT-th WAIT cycle with no valid data.

## Test plan
- Basic fetch: NUM_BODIES=2, BASE_ADDR=0x1000, memory model with latency 1 and data = address -> 8 BODY_WE pulses, (IDX,FIELD) (0,0)..(1,3), BODY_DATA 0x1000..0x101C, DONE at cycle 17, TIMEOUT_ERR=0.
- Waitrequest: hold AVL_WAITREQUEST=1 for 3 cycles on word 2 -> AVL_READ and AVL_ADDR=0x1008 held stable for those cycles, with exactly one accepted read; DONE delayed by 3 cycles.
- Timeout: TIMEOUT=5, suppress READDATAVALID for word 5 -> 5 BODY_WE pulses, TIMEOUT_ERR=1, DONE pulse, back to IDLE. A following START clears TIMEOUT_ERR and refetches all 8 words.
- Boundaries: BASE_ADDR=0xFFFFFFF3 -> first AVL_ADDR 0xFFFFFFF0, then wraps to 0x00000000. START pulses while BUSY -> ignored. Spurious READDATAVALID in IDLE -> no BODY_WE.
- Reset mid-fetch: assert RESET asynchronously during WAIT of word 3 -> all outputs 0 immediately, no DONE pulse. A subsequent START performs a clean full fetch.
